// File: rtl/store_queue.sv
// rtl/store_queue.sv - in-order circular store queue draining committed stores to data memory
module store_queue #(
  parameter int DEPTH = 8,
  parameter int ROB_W = 5,
  localparam int IW = $clog2(DEPTH),
  localparam int PW = IW + 1,
  localparam int LSQ_W = 65 + ROB_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid,
  input  logic [ROB_W-1:0] alloc_rob_tag,
  input  logic             alloc_sh,
  output logic             alloc_ready,
  input  logic             exec_valid,
  input  logic [ROB_W-1:0] exec_rob_tag,
  input  logic [31:0]      exec_addr,
  input  logic [31:0]      exec_data,
  input  logic             commit_valid,
  input  logic [ROB_W-1:0] commit_rob_tag,
  input  logic             flush,
  output logic             store_wb,
  output logic [LSQ_W-1:0] lsq_out,
  output logic [PW-1:0]    sq_count
);

  logic [DEPTH-1:0] valid_q, ready_q, committed_q;
  logic             sh_q   [DEPTH];
  logic [ROB_W-1:0] tag_q  [DEPTH];
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];

  logic [PW-1:0]    head, tail, count, keep_cnt;
  logic [IW-1:0]    head_idx, tail_idx;
  logic [DEPTH-1:0] exec_hit, commit_hit, committed_n;
  logic             drain, do_alloc;

  assign count       = tail - head;
  assign sq_count    = count;
  assign alloc_ready = (count < PW'(DEPTH));
  assign head_idx    = head[IW-1:0];
  assign tail_idx    = tail[IW-1:0];
  assign drain       = valid_q[head_idx] && committed_q[head_idx] && ready_q[head_idx];
  assign do_alloc    = alloc_valid && alloc_ready && !flush;

  always_comb begin
    exec_hit   = '0;
    commit_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      exec_hit[i]   = exec_valid && !flush && valid_q[i] && !ready_q[i] && (tag_q[i] == exec_rob_tag);
      commit_hit[i] = commit_valid && valid_q[i] && (tag_q[i] == commit_rob_tag);
    end
    committed_n = committed_q | commit_hit;
  end

  // Committed entries form a contiguous run from head, so a flush keeps exactly that many.
  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && committed_n[i]) keep_cnt = keep_cnt + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      ready_q     <= '0;
      committed_q <= '0;
      head        <= '0;
      tail        <= '0;
      store_wb    <= 1'b0;
      lsq_out     <= '0;
    end else begin
      store_wb <= drain;
      for (int i = 0; i < DEPTH; i++) begin
        if (exec_hit[i])   ready_q[i]     <= 1'b1;
        if (commit_hit[i]) committed_q[i] <= 1'b1;
      end
      if (drain) begin
        lsq_out               <= {addr_q[head_idx], data_q[head_idx], sh_q[head_idx], tag_q[head_idx]};
        valid_q[head_idx]     <= 1'b0;
        ready_q[head_idx]     <= 1'b0;
        committed_q[head_idx] <= 1'b0;
        head                  <= head + PW'(1);
      end
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (valid_q[i] && !committed_n[i]) begin
            valid_q[i] <= 1'b0;
            ready_q[i] <= 1'b0;
          end
        end
        tail <= head + keep_cnt;
      end else if (do_alloc) begin
        valid_q[tail_idx]     <= 1'b1;
        ready_q[tail_idx]     <= 1'b0;
        committed_q[tail_idx] <= 1'b0;
        tail                  <= tail + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (exec_hit[i]) begin
        addr_q[i] <= exec_addr;
        data_q[i] <= exec_data;
      end
    end
    if (do_alloc) begin
      tag_q[tail_idx] <= alloc_rob_tag;
      sh_q[tail_idx]  <= alloc_sh;
    end
  end

  // Committing a store before its address/data are known is a protocol error.
  assert property (@(posedge clk) disable iff (reset)
    !(|(commit_hit & ~ready_q)));
  assert property (@(posedge clk) disable iff (reset)
    !(do_alloc && exec_valid && (exec_rob_tag == alloc_rob_tag)));
  assert property (@(posedge clk) disable iff (reset)
    !(do_alloc && commit_valid && (commit_rob_tag == alloc_rob_tag)));

endmodule

// File: tb/tb_store_queue.sv
// tb/tb_store_queue.sv - self-checking bench for store_queue against a queue-based model
module tb_store_queue;
  localparam int DEPTH = 8;
  localparam int ROB_W = 5;
  localparam int LW = 65 + ROB_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             alloc_valid = 1'b0;
  logic [ROB_W-1:0] alloc_rob_tag = '0;
  logic             alloc_sh = 1'b0;
  logic             alloc_ready;
  logic             exec_valid = 1'b0;
  logic [ROB_W-1:0] exec_rob_tag = '0;
  logic [31:0]      exec_addr = '0;
  logic [31:0]      exec_data = '0;
  logic             commit_valid = 1'b0;
  logic [ROB_W-1:0] commit_rob_tag = '0;
  logic             flush = 1'b0;
  logic             store_wb;
  logic [LW-1:0]    lsq_out;
  logic [3:0]       sq_count;

  store_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_rob_tag(alloc_rob_tag), .alloc_sh(alloc_sh),
    .alloc_ready(alloc_ready),
    .exec_valid(exec_valid), .exec_rob_tag(exec_rob_tag), .exec_addr(exec_addr),
    .exec_data(exec_data),
    .commit_valid(commit_valid), .commit_rob_tag(commit_rob_tag), .flush(flush),
    .store_wb(store_wb), .lsq_out(lsq_out), .sq_count(sq_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int wb_seen = 0;
  bit chk_en = 0;

  typedef struct {
    logic [ROB_W-1:0] tag;
    logic             sh;
    logic [31:0]      addr;
    logic [31:0]      data;
    bit               rdy;
    bit               cmt;
  } ent_t;

  ent_t          mq[$];
  bit            m_wb = 0;
  logic [LW-1:0] m_lsq = '0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a plain ordered list of stores; drains pop the oldest, flush keeps committed ones.
  always @(posedge clk) begin
    int  n;
    bit  dr;
    ent_t keep[$];
    if (reset) begin
      mq.delete();
      m_wb  = 0;
      m_lsq = '0;
    end else begin
      n  = mq.size();
      dr = (n > 0) && mq[0].rdy && mq[0].cmt;
      for (int i = 0; i < n; i++) begin
        if (exec_valid && !flush && !mq[i].rdy && mq[i].tag == exec_rob_tag) begin
          mq[i].rdy  = 1'b1;
          mq[i].addr = exec_addr;
          mq[i].data = exec_data;
        end
        if (commit_valid && mq[i].tag == commit_rob_tag) mq[i].cmt = 1'b1;
      end
      m_wb = dr;
      if (dr) begin
        m_lsq = {mq[0].addr, mq[0].data, mq[0].sh, mq[0].tag};
        void'(mq.pop_front());
      end
      if (flush) begin
        keep.delete();
        foreach (mq[i]) if (mq[i].cmt) keep.push_back(mq[i]);
        mq = keep;
      end else if (alloc_valid && n < DEPTH) begin
        mq.push_back('{tag: alloc_rob_tag, sh: alloc_sh, addr: '0, data: '0, rdy: 1'b0, cmt: 1'b0});
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("alloc_ready", LW'(alloc_ready), LW'(mq.size() < DEPTH));
      check("sq_count", LW'(sq_count), LW'(mq.size()));
      check("store_wb", LW'(store_wb), LW'(m_wb));
      check("lsq_out", lsq_out, m_lsq);
      if (store_wb) wb_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    alloc_valid  = 1'b0;
    exec_valid   = 1'b0;
    commit_valid = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic set_alloc(input int tag, input bit sh);
    alloc_valid = 1'b1; alloc_rob_tag = ROB_W'(tag); alloc_sh = sh;
  endtask

  task automatic set_exec(input int tag);
    exec_valid = 1'b1; exec_rob_tag = ROB_W'(tag);
    exec_addr = 32'h1000_0000 + 32'(tag) * 4;
    exec_data = 32'hA5A5_0000 ^ 32'(tag);
  endtask

  task automatic set_commit(input int tag);
    commit_valid = 1'b1; commit_rob_tag = ROB_W'(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int w0;
  logic [LW-1:0] exp_v;

  initial begin
    reset = 1'b1;
    tick();
    chk_en = 1;
    tick();
    check("reset_count", LW'(sq_count), '0);
    check("reset_ready", LW'(alloc_ready), LW'(1));
    check("reset_wb", LW'(store_wb), '0);
    check("reset_lsq", lsq_out, '0);
    reset = 1'b0;
    tick();

    // 1: single sw
    set_alloc(3, 0); tick();
    exec_valid = 1'b1; exec_rob_tag = 5'd3; exec_addr = 32'h0001_0020; exec_data = 32'hDEAD_BEEF;
    tick();
    set_commit(3); tick();
    check("t1_wb_not_yet", LW'(store_wb), '0);
    tick();
    check("t1_wb", LW'(store_wb), LW'(1));
    exp_v = {32'h0001_0020, 32'hDEAD_BEEF, 1'b0, 5'd3};
    check("t1_lsq", lsq_out, exp_v);
    tick();
    check("t1_wb_one_cycle", LW'(store_wb), '0);
    check("t1_lsq_hold", lsq_out, exp_v);

    // 2: fill to DEPTH, overflow dropped, drain frees one slot
    for (int t = 0; t < 8; t++) begin set_alloc(t, 0); tick(); end
    check("t2_full_ready", LW'(alloc_ready), '0);
    check("t2_full_count", LW'(sq_count), LW'(8));
    set_alloc(8, 0); tick();
    check("t2_drop_count", LW'(sq_count), LW'(8));
    set_exec(0); tick();
    set_commit(0); tick();
    tick();
    check("t2_drain_wb", LW'(store_wb), LW'(1));
    check("t2_drain_count", LW'(sq_count), LW'(7));
    check("t2_drain_ready", LW'(alloc_ready), LW'(1));
    flush = 1'b1; tick();
    check("t2_flush_count", LW'(sq_count), '0);

    // 3: sh then sw, out-of-order exec, back-to-back commits
    set_alloc(1, 1); tick();
    set_alloc(2, 0); tick();
    set_exec(2); tick();
    set_exec(1); tick();
    set_commit(1); tick();
    set_commit(2); tick();
    check("t3_wb1", LW'(store_wb), LW'(1));
    check("t3_tag1", LW'(lsq_out[5:0]), LW'(6'b1_00001));
    tick();
    check("t3_wb2", LW'(store_wb), LW'(1));
    check("t3_tag2", LW'(lsq_out[5:0]), LW'(6'b0_00010));
    tick();

    // 4: younger committed entry must not bypass head
    set_alloc(4, 0); tick();
    set_alloc(5, 0); tick();
    set_exec(4); tick();
    set_exec(5); tick();
    set_commit(5); tick();
    w0 = wb_seen;
    idle(10);
    check("t4_no_bypass", LW'(wb_seen - w0), '0);
    set_commit(4); tick();
    tick();
    check("t4_tag4", LW'(lsq_out[4:0]), LW'(4));
    tick();
    check("t4_tag5", LW'(lsq_out[4:0]), LW'(5));
    tick();

    // 5: flush keeps the two committed stores
    for (int t = 10; t < 15; t++) begin set_alloc(t, 0); tick(); end
    check("t5_count5", LW'(sq_count), LW'(5));
    for (int t = 10; t < 15; t++) begin set_exec(t); tick(); end
    w0 = wb_seen;
    set_commit(10); tick();
    set_commit(11); flush = 1'b1; tick();
    idle(4);
    check("t5_two_wb", LW'(wb_seen - w0), LW'(2));
    check("t5_empty", LW'(sq_count), '0);
    set_alloc(15, 0); tick();
    check("t5_realloc_count", LW'(sq_count), LW'(1));
    set_exec(15); tick();
    set_commit(15); tick();
    tick();
    check("t5_realloc_tag", LW'(lsq_out[4:0]), LW'(15));
    tick();

    // 6: streaming 20 stores with pointer wrap
    w0 = wb_seen;
    for (int i = 0; i < 22; i++) begin
      if (i < 20) set_alloc(i % 32, 0);
      if (i >= 1 && i < 21) set_exec(i - 1);
      if (i >= 2) set_commit(i - 2);
      tick();
    end
    idle(3);
    check("t6_stream_wb", LW'(wb_seen - w0), LW'(20));
    check("t6_empty", LW'(sq_count), '0);

    // reset mid-stream
    for (int i = 0; i < 6; i++) begin
      set_alloc(20 + i, 0);
      if (i >= 1) set_exec(20 + i - 1);
      if (i >= 2) set_commit(20 + i - 2);
      tick();
    end
    check("t6_mid_wb", LW'(store_wb), LW'(1));
    reset = 1'b1; tick();
    reset = 1'b0;
    check("t6_rst_wb", LW'(store_wb), '0);
    check("t6_rst_count", LW'(sq_count), '0);
    check("t6_rst_ready", LW'(alloc_ready), LW'(1));
    idle(3);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
